// File: rtl/svi_arr_pkg.sv
// Shared types and default sizing for the arrayed-lane reader.
package svi_arr_pkg;

   localparam int DEF_NUM_LANES = 3;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_CNT_W     = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FULL = 1'b1
   } state_t;

   typedef logic [$clog2(DEF_NUM_LANES)-1:0] lane_idx_t;

endpackage

// File: rtl/svi_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module svi_rr_arbiter #(
   parameter int NUM_LANES = 3,
   parameter int IDX_W     = $clog2(NUM_LANES)
) (
   input  logic [NUM_LANES-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic [NUM_LANES-1:0] gnt,
   output logic [IDX_W-1:0]     idx,
   output logic                 found
);

   // Scan every lane once, starting at ptr and wrapping at NUM_LANES.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      gnt   = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (!found && req[(int'(ptr) + k) % NUM_LANES]) begin
            found = 1'b1;
            idx   = IDX_W'((int'(ptr) + k) % NUM_LANES);
         end else begin
            found = found;
            idx   = idx;
         end
      end
      for (int i = 0; i < NUM_LANES; i++) begin
         gnt[i] = found && (idx == IDX_W'(i));
      end
   end

endmodule

// File: rtl/svi_array_reader.sv
// Consumer end of the lane bundle: round-robin capture of one word per cycle
// into a tagged output register, with saturating per-lane transfer counters.
module svi_array_reader
   import svi_arr_pkg::*;
#(
   parameter int NUM_LANES = DEF_NUM_LANES,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_LANES*DATA_W-1:0]   lane_data,
   input  logic [NUM_LANES-1:0]          lane_valid,
   output logic [NUM_LANES-1:0]          lane_ready,
   input  logic [NUM_LANES-1:0]          lane_enable,
   output logic [DATA_W-1:0]             out_data,
   output logic [$clog2(NUM_LANES)-1:0]  out_lane,
   output logic                          out_valid,
   input  logic                          out_ready,
   input  logic                          flush,
   input  logic                          cnt_clr,
   output logic [NUM_LANES*CNT_W-1:0]    lane_cnt,
   output logic                          idle
);

   localparam int LW = $clog2(NUM_LANES);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t              state_r, state_s;
   logic [LW-1:0]       rr_ptr_r, rr_ptr_s, gnt_idx_s, out_lane_r;
   logic [DATA_W-1:0]   out_data_r, gnt_data_s;
   logic [NUM_LANES-1:0] req_s, gnt_s;
   logic                gnt_any_s, window_s;
   logic [CNT_W-1:0]    cnt_r [NUM_LANES];

   // Reset is folded in so no lane sees ready while the block is held in reset.
   assign window_s = rst_n & ~flush & ((state_r == IDLE) | out_ready);
   assign req_s    = lane_valid & lane_enable & {NUM_LANES{window_s}};

   svi_rr_arbiter #(
      .NUM_LANES (NUM_LANES),
      .IDX_W     (LW)
   ) u_arb (
      .req   (req_s),
      .ptr   (rr_ptr_r),
      .gnt   (gnt_s),
      .idx   (gnt_idx_s),
      .found (gnt_any_s)
   );

   // One-hot mux of the granted lane's word.
   always_comb begin
      gnt_data_s = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         gnt_data_s = gnt_data_s | (lane_data[i*DATA_W +: DATA_W] & {DATA_W{gnt_s[i]}});
      end
   end

   // Next state and round-robin pointer; a grant always refills the register.
   always_comb begin
      state_s  = state_r;
      rr_ptr_s = rr_ptr_r;
      if (gnt_any_s) begin
         state_s  = FULL;
         rr_ptr_s = (gnt_idx_s == LW'(NUM_LANES - 1)) ? '0 : gnt_idx_s + LW'(1);
      end else begin
         case (state_r)
            IDLE:    state_s = IDLE;
            FULL:    state_s = (flush || out_ready) ? IDLE : FULL;
            default: state_s = IDLE;
         endcase
      end
   end

   // State, pointer and output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         rr_ptr_r   <= '0;
         out_data_r <= '0;
         out_lane_r <= '0;
      end else begin
         state_r  <= state_s;
         rr_ptr_r <= rr_ptr_s;
         if (gnt_any_s) begin
            out_data_r <= gnt_data_s;
            out_lane_r <= gnt_idx_s;
         end else begin
            out_data_r <= out_data_r;
            out_lane_r <= out_lane_r;
         end
      end
   end

   // Saturating per-lane counters; a clear coinciding with a grant leaves 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            cnt_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (cnt_clr) begin
               cnt_r[i] <= gnt_s[i] ? CNT_W'(1) : '0;
            end else if (gnt_s[i] && (cnt_r[i] != CNT_MAX)) begin
               cnt_r[i] <= cnt_r[i] + CNT_W'(1);
            end else begin
               cnt_r[i] <= cnt_r[i];
            end
         end
      end
   end

   // Flatten counters onto the output bus.
   always_comb begin
      lane_cnt = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_cnt[i*CNT_W +: CNT_W] = cnt_r[i];
      end
   end

   assign out_valid  = (state_r == FULL);
   assign out_data   = out_data_r;
   assign out_lane   = out_lane_r;
   assign lane_ready = gnt_s;
   assign idle       = ~rst_n | ((state_r == IDLE) & ~(|(lane_valid & lane_enable)));

endmodule

// File: doc/svi_array_reader.md
Name: svi_array_reader

Overview:
- Consumer end of the arrayed SV-interface lane bundle. A producer module drives NUM_LANES lanes of DATA_W bits each; this block reads them back.
- Each lane has a valid/ready handshake. The block arbitrates the lanes round-robin and captures one word per cycle into an output register, tagged with the source lane index.
- It keeps a saturating transfer count per lane.
- It sits on the top-level side of the interface array and feeds the top-level outputs or a downstream sink.

Parameters:
- NUM_LANES, 3, number of interface lanes in the array (minimum 2).
- DATA_W, 8, data width of each lane.
- CNT_W, 8, width of each per-lane transfer counter.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- lane_data  input  NUM_LANES*DATA_W  flattened lane data; lane i occupies bits [i*DATA_W +: DATA_W].
- lane_valid  input  NUM_LANES  per-lane word-valid.
- lane_ready  output  NUM_LANES  per-lane accept; at most one bit high per cycle.
- lane_enable  input  NUM_LANES  per-lane arbitration mask; a disabled lane is never granted.
- out_data  output  DATA_W  captured word.
- out_lane  output  $clog2(NUM_LANES)  index of the lane that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accept.
- flush  input  1  synchronous pulse; discards any held word.
- cnt_clr  input  1  synchronous pulse; zeroes all lane counters.
- lane_cnt  output  NUM_LANES*CNT_W  flattened per-lane transfer counts.
- idle  output  1  high when in IDLE and no enabled lane is valid.

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM goes to IDLE.
  - out_valid=0, out_data=0, out_lane=0.
  - rr_ptr=0, all lane_cnt=0.
  - lane_ready=0, idle=1.
- FSM states:
  - IDLE: output register empty.
  - FULL: out_valid=1.
- Capture window: open when state==IDLE, or state==FULL && out_ready (drain and refill in the same cycle). Flush closes the window for that cycle.
- Grant (combinational, in-window only):
  - Scan lanes starting at rr_ptr with modulo-NUM_LANES wrap.
  - Grant the first lane i with lane_valid[i] && lane_enable[i].
  - lane_ready[i]=1 for the granted lane only; all other bits are 0.
  - No candidate means no grant.
- On a grant edge:
  - out_data <= lane i data, out_lane <= i.
  - FSM goes to FULL.
  - rr_ptr <= i+1; if i==NUM_LANES-1, rr_ptr <= 0.
  - lane_cnt[i] increments, saturating at 2^CNT_W-1.
  - Latency: 1 cycle from the lane handshake to out_valid.
- FULL && out_ready && no grant: go to IDLE, out_valid=0.
- FULL && !out_ready: hold out_data and out_lane stable; lane_ready=0.
- No grant in the window: rr_ptr holds.
- flush:
  - Goes to IDLE and clears out_valid, regardless of out_ready.
  - No grant that cycle; rr_ptr unchanged.
  - Counters unaffected.
- cnt_clr:
  - Zeroes all counters.
  - If it coincides with a grant to lane i, lane_cnt[i]=1 and all others are 0.
- Disabling a lane mid-stream: takes effect the same cycle. A word already in the output register is unaffected.
- Single candidate: a single continuously valid enabled lane is granted every cycle while out_ready=1, giving full throughput.
- Reset mid-transfer: any held word is lost. There is no recovery handshake.
- Datapath is pure capture: no arithmetic on data. Counter increments are DATA-independent.

Decomposition:
- Package svi_arr_pkg holds:
  - state enum {IDLE, FULL};
  - default NUM_LANES, DATA_W and CNT_W localparams;
  - lane-index typedef logic [$clog2(NUM_LANES)-1:0].
- Sub-module svi_rr_arbiter takes request vector and rr_ptr, and returns a one-hot grant and the encoded index. It is purely combinational.
- The top level owns the FSM, output register and counters.

Test Plan:
- Constant lanes: lane0=0x00, lane1=0xFF, lane2=0xA5, all valid and enabled, out_ready=1 → out sequence (lane,data) is (0,0x00), (1,0xFF), (2,0xA5), (0,0x00), one word per cycle; lane_cnt reads 2,1,1 after 4 words.
- Backpressure: lane1 only valid, data=0x3C; out_ready low for 5 cycles → out_valid=1 and out_data=0x3C held stable, lane_ready=0; on release, the next word is accepted the same cycle.
- Masking: all lanes valid, lane_enable=3'b101 → lane1 is never granted; order is 0,2,0,2.
- Flush and clear: out_valid=1 and flush pulsed → out_valid=0 next cycle, rr_ptr unchanged. cnt_clr together with a grant to lane2 → lane_cnt={1,0,0} (lane2,lane1,lane0).
- Saturation: CNT_W=2, lane0 streams 6 words → lane_cnt[0] sticks at 3.
- Async reset: assert rst_n low mid-cycle while FULL → out_valid, lane_ready and counters clear immediately, without waiting for a clock edge.
